// File: rtl/coo_adj_responder.sv
// Memory-side responder for the COO adjacency traversal: serially loads the 2 x N index
// table, then serves entry pointer, self-loop flag and the selected FM*WM row index.
module coo_adj_responder #(
    parameter int FM_WM_ROWS      = 6,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_NUM_OF_ROWS = 2,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
    parameter int IDX_W           = $clog2(FM_WM_ROWS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [2*IDX_W-1:0] load_data,
    output logic               done,
    input  logic               coo_incr,
    input  logic               cnt_reset,
    input  logic               fm_wm_row,
    input  logic               adj_fm_wm_done,
    output logic [COO_BW-1:0]  coo_address,
    output logic               skip,
    output logic [IDX_W-1:0]   fm_wm_addr,
    output logic               idx_err
);

    typedef enum logic {
        LOAD  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic [COO_BW-1:0] LAST_COL   = COO_BW'(COO_NUM_OF_COLS - 1);
    localparam logic [IDX_W:0]    ROWS_LIMIT = (IDX_W + 1)'(FM_WM_ROWS);

    state_t            state_q, state_d;
    logic [COO_BW-1:0] load_cnt_q, load_cnt_d;
    logic [COO_BW-1:0] ptr_q, ptr_d;
    logic              idx_err_q, idx_err_d;
    logic [IDX_W-1:0]  tbl_q [COO_NUM_OF_ROWS][COO_NUM_OF_COLS];

    logic [IDX_W-1:0]  src_idx;
    logic [IDX_W-1:0]  nbr_idx;
    logic              load_hs;
    logic              bad_idx;

    assign src_idx = load_data[IDX_W-1:0];
    assign nbr_idx = load_data[2*IDX_W-1:IDX_W];
    assign load_hs = load_valid && load_ready;
    assign bad_idx = ({1'b0, src_idx} >= ROWS_LIMIT) || ({1'b0, nbr_idx} >= ROWS_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            ptr_q      <= '0;
            idx_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            ptr_q      <= ptr_d;
            idx_err_q  <= idx_err_d;
        end
    end

    // Out-of-range words are still stored; idx_err only flags them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < COO_NUM_OF_ROWS; r++) begin
                for (int c = 0; c < COO_NUM_OF_COLS; c++) begin
                    tbl_q[r][c] <= '0;
                end
            end
        end else if (load_hs) begin
            tbl_q[0][load_cnt_q] <= src_idx;
            tbl_q[1][load_cnt_q] <= nbr_idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        ptr_d      = ptr_q;
        idx_err_d  = idx_err_q;
        load_ready = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            LOAD: begin
                load_ready = 1'b1;
                ptr_d      = '0;
                if (load_hs) begin
                    if (bad_idx) begin
                        idx_err_d = 1'b1;
                    end
                    if (load_cnt_q == LAST_COL) begin
                        load_cnt_d = '0;
                        state_d    = SERVE;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            SERVE: begin
                done = 1'b1;
                if (adj_fm_wm_done) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end else if (cnt_reset) begin
                    ptr_d = '0;
                end else if (coo_incr && (ptr_q != LAST_COL)) begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign coo_address = ptr_q;
    assign skip        = (tbl_q[0][ptr_q] == tbl_q[1][ptr_q]);
    assign fm_wm_addr  = tbl_q[fm_wm_row][ptr_q];
    assign idx_err     = idx_err_q;

endmodule

// File: tb/tb_coo_adj_responder.sv
// Bench for coo_adj_responder: directed plan plus random traffic against a table-level model.
module tb_coo_adj_responder;

    localparam int ROWS = 6;
    localparam int COLS = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [5:0] load_data;
    logic       done;
    logic       coo_incr;
    logic       cnt_reset;
    logic       fm_wm_row;
    logic       adj_fm_wm_done;
    logic [2:0] coo_address;
    logic       skip;
    logic [2:0] fm_wm_addr;
    logic       idx_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: table contents, phase, fill count and pointer.
    int m_src [COLS];
    int m_nbr [COLS];
    bit m_serving;
    int m_fill;
    int m_ptr;
    bit m_err;

    always #5 clk = ~clk;

    coo_adj_responder dut (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_data      (load_data),
        .done           (done),
        .coo_incr       (coo_incr),
        .cnt_reset      (cnt_reset),
        .fm_wm_row      (fm_wm_row),
        .adj_fm_wm_done (adj_fm_wm_done),
        .coo_address    (coo_address),
        .skip           (skip),
        .fm_wm_addr     (fm_wm_addr),
        .idx_err        (idx_err)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < COLS; c++) begin
            m_src[c] = 0;
            m_nbr[c] = 0;
        end
        m_serving = 0;
        m_fill    = 0;
        m_ptr     = 0;
        m_err     = 0;
    endtask

    task automatic check_outs();
        chk("done",        int'(done),        int'(m_serving));
        chk("load_ready",  int'(load_ready),  int'(!m_serving));
        chk("coo_address", int'(coo_address), m_ptr);
        chk("skip",        int'(skip),        int'(m_src[m_ptr] == m_nbr[m_ptr]));
        chk("fm_wm_addr",  int'(fm_wm_addr),  fm_wm_row ? m_nbr[m_ptr] : m_src[m_ptr]);
        chk("idx_err",     int'(idx_err),     int'(m_err));
    endtask

    // One clock: drive after the falling edge, check, then advance the model at the rising edge.
    task automatic cyc(input bit lv, input int d0, input int d1, input bit incr,
                       input bit cr, input bit row, input bit adj);
        load_valid     = lv;
        load_data      = {3'(d1), 3'(d0)};
        coo_incr       = incr;
        cnt_reset      = cr;
        fm_wm_row      = row;
        adj_fm_wm_done = adj;
        #1;
        check_outs();
        @(posedge clk);
        if (!m_serving) begin
            if (lv) begin
                m_src[m_fill] = d0;
                m_nbr[m_fill] = d1;
                if (d0 >= ROWS || d1 >= ROWS) m_err = 1;
                m_fill++;
                if (m_fill == COLS) begin
                    m_fill    = 0;
                    m_serving = 1;
                end
            end
        end else if (adj) begin
            m_serving = 0;
            m_ptr     = 0;
        end else if (cr) begin
            m_ptr = 0;
        end else if (incr && m_ptr < COLS - 1) begin
            m_ptr++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit row);
        cyc(0, 0, 0, 0, 0, row, 0);
    endtask

    task automatic incr_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 1, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load_valid = 0; coo_incr = 0; cnt_reset = 0; adj_fm_wm_done = 0;
        #1;
        model_reset();
        check_outs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    int plan_a0 [COLS] = '{0, 1, 2, 3, 4, 5};
    int plan_a1 [COLS] = '{1, 1, 0, 3, 5, 2};
    int plan_b0 [COLS] = '{6, 1, 2, 3, 4, 5};
    int plan_b1 [COLS] = '{0, 2, 2, 4, 0, 5};

    initial begin
        reset = 1'b1;
        load_valid = 0; load_data = '0; coo_incr = 0; cnt_reset = 0;
        fm_wm_row = 0; adj_fm_wm_done = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outs();
        chk("rst_skip", int'(skip), 1);
        reset = 1'b0;

        // Continuous load of the plan table.
        for (int i = 0; i < COLS; i++) begin
            cyc(1, plan_a0[i], plan_a1[i], 0, 0, 0, 0);
            if (i < COLS - 1) chk("load_rdy_hold", int'(load_ready), 1);
        end
        chk("plan_done", int'(done), 1);
        chk("plan_rdy_low", int'(load_ready), 0);
        chk("plan_addr0", int'(coo_address), 0);
        chk("plan_skip0", int'(skip), 0);
        fm_wm_row = 0; #1 chk("plan_fm_r0", int'(fm_wm_addr), 0);
        fm_wm_row = 1; #1 chk("plan_fm_r1", int'(fm_wm_addr), 1);
        idle(0);
        idle(1);

        incr_n(1);
        chk("incr1_addr", int'(coo_address), 1);
        chk("incr1_skip", int'(skip), 1);
        chk("incr1_fm",   int'(fm_wm_addr), 1);
        incr_n(4);
        chk("incr5_addr", int'(coo_address), 5);
        incr_n(1);
        chk("sat_addr", int'(coo_address), 5);

        cyc(0, 0, 0, 0, 1, 0, 0);
        incr_n(3);
        chk("pre_clr_addr", int'(coo_address), 3);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("clr_prio_addr", int'(coo_address), 0);

        incr_n(4);
        chk("pre_adj_addr", int'(coo_address), 4);
        cyc(0, 0, 0, 1, 0, 0, 1);
        chk("adj_done", int'(done), 0);
        chk("adj_rdy", int'(load_ready), 1);
        chk("adj_addr", int'(coo_address), 0);

        // Toggling valid with an out-of-range first word.
        for (int i = 0; i < 2 * COLS; i++) begin
            if (i % 2 == 0) cyc(1, plan_b0[i / 2], plan_b1[i / 2], 0, 0, 0, 0);
            else            cyc(0, 7, 7, 0, 0, 0, 0);
            if (i < 2 * COLS - 2) chk("tog_not_done", int'(done), 0);
        end
        chk("tog_done", int'(done), 1);
        chk("tog_err", int'(idx_err), 1);
        idle(1);

        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, i, i + 1, 0, 0, 0, 0);
        chk("err_sticky", int'(idx_err), 1);
        do_reset();
        chk("midrst_done", int'(done), 0);
        chk("midrst_rdy", int'(load_ready), 1);
        chk("midrst_skip", int'(skip), 1);
        chk("midrst_err", int'(idx_err), 0);
        for (int i = 0; i < COLS; i++) begin
            cyc(1, plan_a0[i], plan_a1[i], 0, 0, 0, 0);
            if (i == COLS - 2) chk("reload_5_not_done", int'(done), 0);
        end
        chk("reload_done", int'(done), 1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc(bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 19) == 0) ? 6 + $urandom_range(0, 1) : $urandom_range(0, 5),
                    $urandom_range(0, 5),
                    bit'($urandom_range(0, 1)),
                    $urandom_range(0, 9) == 0,
                    bit'($urandom_range(0, 1)),
                    $urandom_range(0, 24) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
